mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline MEM stage of the RV32 core: consumes the EX/MEM register produced by the execute stage, performs loads and stores over a Wishbone-classic data bus, and owns the MEM/WB register. The MEM/WB register feeds writeback and the `fwd_mem_*` forwarding inputs of the execute stage. While a bus access is outstanding it stalls the upstream pipeline. It also detects misaligned accesses and bus errors.

## Interface
Parameters: none. Widths are fixed by RV32.

- `clk`  in  1  pipeline clock
- `rst`  in  1  reset, asynchronous, active-high
- `ex_mem_reg`  in  `ex_mem_reg_t`  fields used: `alu_result` (address/result), `rs2_data`, `rd`, `mem_read`, `mem_write`, `mem_unsigned`, `mem_width`, `reg_write`, `mem_to_reg`, `valid`
- `mem_stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM this cycle
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  registered bus controls
- `wb_adr_o`  out  32  word-aligned address, `{alu_result[31:2],2'b00}`
- `wb_dat_o`  out  32  store data
- `wb_sel_o`  out  4  byte lanes
- `wb_dat_i`  in  32  read data
- `wb_ack_i`  in  1  transfer complete
- `wb_err_i`  in  1  transfer failed
- `mem_wb_reg`  out  `mem_wb_reg_t`  registered fields: `wb_data[31:0]`, `rd[4:0]`, `reg_write`, `valid`
- `mem_exc`  out  1  one-cycle pulse: misaligned access or bus error
- `mem_exc_cause`  out  2  0 load-misaligned, 1 store-misaligned, 2 load-fault, 3 store-fault
- `mem_exc_addr`  out  32  faulting byte address (`alu_result`)

## Operation
- The `mem_width` encoding is fixed: 00 = byte, 01 = half, 10 = word. An access is a memory op when `valid & (mem_read | mem_write)`.
- Misalignment rules:
  - half is misaligned when `addr[0]=1`
  - word is misaligned when `addr[1:0]≠0`
  - byte is never misaligned
  - A misaligned op makes no bus access and causes no stall. `mem_exc` pulses with the matching cause. MEM/WB captures `valid=1`, `reg_write=0`.
- FSM states: IDLE, BUS.
  - IDLE with an aligned memory op: assert `mem_stall`. On the next edge, register the bus outputs (`cyc=stb=1`, `we=mem_write`, `adr`, `sel`, `dat_o`) and go to BUS.
  - BUS without `ack`/`err`: `mem_stall=1`, bus outputs held stable.
  - BUS with `ack` or `err`: `mem_stall=0`, so EX/MEM advances on this edge. MEM/WB captures the result. `cyc`/`stb`/`we` clear. Next state is IDLE.
  - If `err`: `mem_exc` pulses in that cycle with cause 2 (load) or 3 (store), and MEM/WB gets `reg_write=0`.
- Byte lanes: byte `sel=4'b0001<<addr[1:0]`; half `sel=4'b0011<<addr[1:0]`; word `sel=4'hF`.
- Store data: byte `{4{rs2[7:0]}}`; half `{2{rs2[15:0]}}`; word `rs2`.
- Load data:
  - `sh = wb_dat_i >> (8*addr[1:0])`
  - byte: `sh[7:0]` extended to 32 bits
  - half: `sh[15:0]` extended to 32 bits
  - Extension is zero-extension when `mem_unsigned=1`, sign-extension otherwise. Word loads are taken unmodified.
- `wb_data = mem_to_reg ? load_data : alu_result`. Jump and CSR results already arrive in `alu_result`.
- Stores and non-memory ops write MEM/WB with `reg_write` passed through (stores arrive with 0).
- While `mem_stall=1`, MEM/WB captures a bubble (all zero) each edge, so writeback is never duplicated.
- `ack`/`err` seen in IDLE are ignored. `err` takes precedence over `ack` when both are asserted.

## Timing
- Reset values:
  - state IDLE
  - all `wb_*_o` = 0
  - `mem_wb_reg` = 0
  - `mem_exc`, `mem_exc_cause`, `mem_exc_addr` = 0
  - `mem_stall` = 0, given `ex_mem_reg.valid=0`
- Non-memory or misaligned op: no stall. MEM/WB is valid on the next edge.
- Aligned memory op with N wait states: the instruction occupies MEM for N+2 cycles. The stall lasts N+1 cycles. The ack cycle is unstalled. MEM/WB is valid on the edge that ends the ack cycle.
- Back-to-back memory ops: the second op is in IDLE the cycle after the ack, so there is no bus idle gap beyond one cycle.
- `mem_stall` and `mem_exc` are combinational from state, `ex_mem_reg` and the bus inputs. All other outputs are registered.
- Reset asserted mid-BUS drops `cyc`/`stb` immediately and asynchronously. The access is abandoned.

## Test plan
- LB: `alu_result=0x1003`, `wb_dat_i=0x80AA5511`, ack after 0 waits → `sel=1000`, `mem_stall` high exactly 1 cycle, `wb_data=0xFFFFFF80`. The same access as LBU → `0x00000080`.
- SH: `addr=0x2002`, `rs2=0x1234ABCD` → `adr=0x2000`, `sel=1100`, `dat_o=0xABCDABCD`, `we=1`, MEM/WB `reg_write=0`.
- LW at `0x3001` → no `cyc`, `mem_exc=1`, cause 0, `mem_exc_addr=0x3001`, MEM/WB `reg_write=0`, no stall.
- LW with 3 wait states, then an ADD (`alu_result=7`) → stall 4 cycles, bus outputs stable throughout, one MEM/WB load entry followed by the ADD entry with `wb_data=7`, with bubbles in between.
- SW with `err_i` (and simultaneous `ack`) on the first BUS cycle → cause 3, single `mem_exc` pulse, state returns to IDLE.
- `rst` asserted during BUS → all `wb_*_o`=0 and `mem_wb_reg`=0 without waiting for a clock edge; a later `ack` is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// RV32 MEM stage: Wishbone-classic loads/stores, misalignment/bus-error detection,
// upstream stall while a transfer is outstanding, and the MEM/WB register.
package mem_access_pkg;
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        mem_unsigned;
    logic [1:0]  mem_width;
    logic        reg_write;
    logic        mem_to_reg;
    logic        valid;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        valid;
  } mem_wb_reg_t;
endpackage

module mem_access_stage
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_reg_t ex_mem_reg,
  output logic        mem_stall,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output mem_wb_reg_t mem_wb_reg,
  output logic        mem_exc,
  output logic [1:0]  mem_exc_cause,
  output logic [31:0] mem_exc_addr
);
  typedef enum logic {IDLE, BUS} state_t;
  state_t state, state_n;

  logic [31:0] addr;
  logic        is_mem, misal, done;
  logic [3:0]  sel;
  logic [31:0] st_data, sh, ld_data, res_data;

  assign addr   = ex_mem_reg.alu_result;
  assign is_mem = ex_mem_reg.valid & (ex_mem_reg.mem_read | ex_mem_reg.mem_write);
  assign misal  = is_mem & ((ex_mem_reg.mem_width == 2'b01 & addr[0]) |
                            (ex_mem_reg.mem_width[1] & (addr[1:0] != 2'b00)));
  assign done   = wb_ack_i | wb_err_i;

  always_comb begin
    sel     = 4'hF;
    st_data = ex_mem_reg.rs2_data;
    case (ex_mem_reg.mem_width)
      2'b00: begin
        sel     = 4'b0001 << addr[1:0];
        st_data = {4{ex_mem_reg.rs2_data[7:0]}};
      end
      2'b01: begin
        sel     = 4'b0011 << addr[1:0];
        st_data = {2{ex_mem_reg.rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign sh = wb_dat_i >> {addr[1:0], 3'b000};

  always_comb begin
    ld_data = wb_dat_i;
    case (ex_mem_reg.mem_width)
      2'b00: ld_data = {{24{~ex_mem_reg.mem_unsigned & sh[7]}}, sh[7:0]};
      2'b01: ld_data = {{16{~ex_mem_reg.mem_unsigned & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

  assign res_data = ex_mem_reg.mem_to_reg ? ld_data : ex_mem_reg.alu_result;

  always_comb begin
    state_n       = state;
    mem_stall     = 1'b0;
    mem_exc       = 1'b0;
    mem_exc_cause = 2'd0;
    mem_exc_addr  = 32'd0;
    case (state)
      IDLE: begin
        if (misal) begin
          mem_exc       = 1'b1;
          mem_exc_cause = {1'b0, ex_mem_reg.mem_write};
          mem_exc_addr  = addr;
        end else if (is_mem) begin
          mem_stall = 1'b1;
          state_n   = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          mem_exc       = 1'b1;
          mem_exc_cause = {1'b1, ex_mem_reg.mem_write};
          mem_exc_addr  = addr;
          state_n       = IDLE;
        end else if (wb_ack_i) begin
          state_n = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= 32'd0;
      wb_dat_o   <= 32'd0;
      wb_sel_o   <= 4'd0;
      mem_wb_reg <= '0;
    end else begin
      // Default is a bubble; only unstalled edges retire an instruction.
      mem_wb_reg <= '0;
      case (state)
        IDLE: begin
          if (is_mem & ~misal) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= ex_mem_reg.mem_write;
            wb_adr_o <= {addr[31:2], 2'b00};
            wb_sel_o <= sel;
            wb_dat_o <= st_data;
          end else if (ex_mem_reg.valid) begin
            mem_wb_reg.wb_data   <= ex_mem_reg.alu_result;
            mem_wb_reg.rd        <= ex_mem_reg.rd;
            mem_wb_reg.reg_write <= ex_mem_reg.reg_write & ~misal;
            mem_wb_reg.valid     <= 1'b1;
          end
        end
        BUS: begin
          if (done) begin
            wb_cyc_o             <= 1'b0;
            wb_stb_o             <= 1'b0;
            wb_we_o              <= 1'b0;
            mem_wb_reg.wb_data   <= res_data;
            mem_wb_reg.rd        <= ex_mem_reg.rd;
            mem_wb_reg.reg_write <= ex_mem_reg.reg_write & ~wb_err_i;
            mem_wb_reg.valid     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment, wait states,
// bus error and asynchronous reset during a transfer.
`timescale 1ns/1ps
module tb_mem_access_stage;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  ex_mem_reg_t ex;
  logic        mem_stall;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic        ack, err;
  mem_wb_reg_t mwb;
  logic        exc;
  logic [1:0]  cause;
  logic [31:0] exc_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .ex_mem_reg(ex), .mem_stall(mem_stall),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
    .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_dat_i(dat_i), .wb_ack_i(ack),
    .wb_err_i(err), .mem_wb_reg(mwb), .mem_exc(exc),
    .mem_exc_cause(cause), .mem_exc_addr(exc_addr)
  );

  task automatic set_op(input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rdop, input logic wrop, input logic uns,
                        input logic [1:0] w, input logic rw, input logic m2r);
    ex = '0;
    ex.alu_result = a;  ex.rs2_data = rs2; ex.rd = rd;
    ex.mem_read = rdop; ex.mem_write = wrop; ex.mem_unsigned = uns;
    ex.mem_width = w;   ex.reg_write = rw;  ex.mem_to_reg = m2r;
    ex.valid = 1'b1;
  endtask

  task automatic test_reset();
    ex = '0; ack = 0; err = 0; dat_i = 0;
    rst = 1'b1;
    #12;
    checks++;
    if ({cyc, stb, we, adr, dat_o, sel} !== 71'd0) begin
      failures++; $display("FAIL reset_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b want all 0", cyc, stb, we, adr, dat_o, sel);
    end
    checks++;
    if (mwb !== '0 || mem_stall !== 1'b0 || exc !== 1'b0 || cause !== 2'd0 || exc_addr !== 32'd0) begin
      failures++; $display("FAIL reset_regs: got mwb=%h stall=%b exc=%b cause=%0d addr=%h want 0", mwb, mem_stall, exc, cause, exc_addr);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lb(input logic uns, input logic [31:0] exp);
    set_op(32'h1003, 32'h0, 5'd5, 1, 0, uns, 2'b00, 1, 1);
    #1;
    checks++;
    if (mem_stall !== 1'b1 || cyc !== 1'b0) begin
      failures++; $display("FAIL lb_idle: got stall=%b cyc=%b want stall=1 cyc=0", mem_stall, cyc);
    end
    @(negedge clk);
    checks++;
    if (cyc !== 1 || stb !== 1 || we !== 0 || sel !== 4'b1000 || adr !== 32'h1000 || mwb !== '0) begin
      failures++; $display("FAIL lb_bus: got cyc=%b stb=%b we=%b sel=%b adr=%h mwb=%h want 1 1 0 1000 00001000 0", cyc, stb, we, sel, adr, mwb);
    end
    ack = 1; dat_i = 32'h80AA5511;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      failures++; $display("FAIL lb_ack_stall: got %b want 0", mem_stall);
    end
    @(negedge clk);
    ack = 0; ex = '0;
    checks++;
    if (mwb.wb_data !== exp || mwb.rd !== 5'd5 || mwb.reg_write !== 1 || mwb.valid !== 1 || cyc !== 0) begin
      failures++; $display("FAIL lb_result uns=%b: got data=%h rd=%0d rw=%b v=%b cyc=%b want %h 5 1 1 0", uns, mwb.wb_data, mwb.rd, mwb.reg_write, mwb.valid, cyc, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_sh();
    set_op(32'h2002, 32'h1234ABCD, 5'd0, 0, 1, 0, 2'b01, 0, 0);
    @(negedge clk);
    checks++;
    if (adr !== 32'h2000 || sel !== 4'b1100 || dat_o !== 32'hABCDABCD || we !== 1 || cyc !== 1) begin
      failures++; $display("FAIL sh_bus: got adr=%h sel=%b dat=%h we=%b cyc=%b want 00002000 1100 abcdabcd 1 1", adr, sel, dat_o, we, cyc);
    end
    ack = 1;
    @(negedge clk);
    ack = 0; ex = '0;
    checks++;
    if (mwb.valid !== 1 || mwb.reg_write !== 0 || we !== 0 || cyc !== 0) begin
      failures++; $display("FAIL sh_result: got v=%b rw=%b we=%b cyc=%b want 1 0 0 0", mwb.valid, mwb.reg_write, we, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    set_op(32'h3001, 32'h0, 5'd3, 1, 0, 0, 2'b10, 1, 1);
    #1;
    checks++;
    if (exc !== 1 || cause !== 2'd0 || exc_addr !== 32'h3001 || mem_stall !== 0) begin
      failures++; $display("FAIL lw_misal: got exc=%b cause=%0d addr=%h stall=%b want 1 0 00003001 0", exc, cause, exc_addr, mem_stall);
    end
    @(negedge clk);
    set_op(32'h2001, 32'h55, 5'd0, 0, 1, 0, 2'b01, 0, 0);
    checks++;
    if (cyc !== 0 || mwb.valid !== 1 || mwb.reg_write !== 0 || mwb.rd !== 5'd3) begin
      failures++; $display("FAIL lw_misal_wb: got cyc=%b v=%b rw=%b rd=%0d want 0 1 0 3", cyc, mwb.valid, mwb.reg_write, mwb.rd);
    end
    #1;
    checks++;
    if (exc !== 1 || cause !== 2'd1 || exc_addr !== 32'h2001 || mem_stall !== 0) begin
      failures++; $display("FAIL sh_misal: got exc=%b cause=%0d addr=%h stall=%b want 1 1 00002001 0", exc, cause, exc_addr, mem_stall);
    end
    @(negedge clk);
    ex = '0;
    checks++;
    if (cyc !== 0) begin
      failures++; $display("FAIL sh_misal_bus: got cyc=%b want 0", cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    int stalls = 0;
    set_op(32'h4000, 32'h0, 5'd7, 1, 0, 0, 2'b10, 1, 1);
    dat_i = 32'hDEADBEEF;
    #1;
    if (mem_stall) stalls++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (mem_stall) stalls++;
      checks++;
      if (cyc !== 1 || stb !== 1 || we !== 0 || adr !== 32'h4000 || sel !== 4'hF || mwb !== '0) begin
        failures++; $display("FAIL ws_hold%0d: got cyc=%b stb=%b we=%b adr=%h sel=%b mwb=%h want 1 1 0 00004000 1111 0", i, cyc, stb, we, adr, sel, mwb);
      end
    end
    @(negedge clk);
    ack = 1;
    #1;
    if (mem_stall) stalls++;
    checks++;
    if (stalls !== 4) begin
      failures++; $display("FAIL ws_stall_count: got %0d want 4", stalls);
    end
    @(negedge clk);
    ack = 0;
    set_op(32'd7, 32'h0, 5'd8, 0, 0, 0, 2'b10, 1, 0);
    checks++;
    if (mwb.wb_data !== 32'hDEADBEEF || mwb.rd !== 5'd7 || mwb.reg_write !== 1 || mwb.valid !== 1) begin
      failures++; $display("FAIL ws_load: got data=%h rd=%0d rw=%b v=%b want deadbeef 7 1 1", mwb.wb_data, mwb.rd, mwb.reg_write, mwb.valid);
    end
    #1;
    checks++;
    if (mem_stall !== 0) begin
      failures++; $display("FAIL ws_add_stall: got %b want 0", mem_stall);
    end
    @(negedge clk);
    ex = '0;
    checks++;
    if (mwb.wb_data !== 32'd7 || mwb.rd !== 5'd8 || mwb.reg_write !== 1 || mwb.valid !== 1) begin
      failures++; $display("FAIL ws_add: got data=%h rd=%0d rw=%b v=%b want 00000007 8 1 1", mwb.wb_data, mwb.rd, mwb.reg_write, mwb.valid);
    end
    @(negedge clk);
  endtask

  task automatic test_err();
    int pulses = 0;
    set_op(32'h5000, 32'hCAFEF00D, 5'd0, 0, 1, 0, 2'b10, 0, 0);
    #1;
    if (exc) pulses++;
    @(negedge clk);
    ack = 1; err = 1;
    #1;
    if (exc) pulses++;
    checks++;
    if (exc !== 1 || cause !== 2'd3 || exc_addr !== 32'h5000 || mem_stall !== 0) begin
      failures++; $display("FAIL sw_err: got exc=%b cause=%0d addr=%h stall=%b want 1 3 00005000 0", exc, cause, exc_addr, mem_stall);
    end
    @(negedge clk);
    ex = '0;
    #1;
    if (exc) pulses++;
    ack = 0; err = 0;
    checks++;
    if (pulses !== 1 || cyc !== 0 || mwb.valid !== 1 || mwb.reg_write !== 0) begin
      failures++; $display("FAIL sw_err_after: got pulses=%0d cyc=%b v=%b rw=%b want 1 0 1 0", pulses, cyc, mwb.valid, mwb.reg_write);
    end
    // A new aligned op must see IDLE again: stall asserted, bus not yet driven.
    set_op(32'h5004, 32'h0, 5'd2, 1, 0, 0, 2'b10, 1, 1);
    #1;
    checks++;
    if (mem_stall !== 1 || cyc !== 0) begin
      failures++; $display("FAIL sw_err_idle: got stall=%b cyc=%b want 1 0", mem_stall, cyc);
    end
    @(negedge clk);
    ack = 1;
    @(negedge clk);
    ack = 0; ex = '0;
    @(negedge clk);
  endtask

  task automatic test_idle_ack();
    ack = 1; err = 1;
    #1;
    checks++;
    if (exc !== 0 || mem_stall !== 0) begin
      failures++; $display("FAIL idle_ack: got exc=%b stall=%b want 0 0", exc, mem_stall);
    end
    @(negedge clk);
    ack = 0; err = 0;
    checks++;
    if (cyc !== 0 || mwb !== '0) begin
      failures++; $display("FAIL idle_ack_wb: got cyc=%b mwb=%h want 0 0", cyc, mwb);
    end
  endtask

  task automatic test_rst_mid_bus();
    set_op(32'h6008, 32'h0, 5'd9, 1, 0, 0, 2'b10, 1, 1);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    checks++;
    if ({cyc, stb, we, adr, dat_o, sel} !== 71'd0 || mwb !== '0) begin
      failures++; $display("FAIL rst_async: got cyc=%b stb=%b adr=%h sel=%b mwb=%h want all 0", cyc, stb, adr, sel, mwb);
    end
    ex = '0;
    @(negedge clk);
    rst = 0;
    ack = 1; dat_i = 32'h12345678;
    #1;
    checks++;
    if (mem_stall !== 0 || exc !== 0) begin
      failures++; $display("FAIL rst_late_ack: got stall=%b exc=%b want 0 0", mem_stall, exc);
    end
    @(negedge clk);
    ack = 0;
    checks++;
    if (mwb !== '0 || cyc !== 0) begin
      failures++; $display("FAIL rst_late_ack_wb: got mwb=%h cyc=%b want 0 0", mwb, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_lb(1'b0, 32'hFFFFFF80);
    test_lb(1'b1, 32'h00000080);
    test_sh();
    test_misaligned();
    test_wait_states();
    test_err();
    test_idle_ack();
    test_rst_mid_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
